// File: rtl/rns_pkg.sv
// Shared definitions for the sequential binary-to-RNS forward converter
// over the moduli set {2^N-1, 2^N, 2^N+1}.
package rns_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned num_chunks(input int unsigned w, input int unsigned n);
    return (w + n - 1) / n;
  endfunction

  function automatic int unsigned mod_m1(input int unsigned n);
    return (1 << n) - 1;
  endfunction

  function automatic int unsigned mod_p1(input int unsigned n);
    return (1 << n) + 1;
  endfunction

  localparam int unsigned DEF_N  = 4;
  localparam int unsigned MOD_M1 = mod_m1(DEF_N);
  localparam int unsigned MOD_P1 = mod_p1(DEF_N);

endpackage

// File: rtl/rns_modstep.sv
// Combinational single-chunk update of the mod (2^N-1) and mod (2^N+1)
// accumulators; sub selects the alternating-sign term for 2^N+1.
module rns_modstep
  import rns_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] acc_m1,
  input  logic [N:0]   acc_p1,
  input  logic [N-1:0] chunk,
  input  logic         sub,
  output logic [N-1:0] nxt_m1,
  output logic [N:0]   nxt_p1
);

  localparam logic [N+1:0] P1 = (N+2)'(mod_p1(N));

  logic [N:0]   sum_m1;
  logic [N+1:0] t_p1;

  // End-around carry keeps acc_m1 in 0..2^N-1, where 2^N-1 aliases zero.
  always_comb begin
    sum_m1 = {1'b0, acc_m1} + {1'b0, chunk};
    nxt_m1 = sum_m1[N-1:0] + {{(N-1){1'b0}}, sum_m1[N]};
  end

  // Add range 0..2^(N+1)-1 or signed subtract range -(2^N-1)..2^N both fit
  // N+2 bits, so a single conditional +/-(2^N+1) lands in 0..2^N.
  always_comb begin
    if (sub) begin
      t_p1 = {1'b0, acc_p1} - {2'b00, chunk};
      if (t_p1[N+1]) t_p1 = t_p1 + P1;
    end else begin
      t_p1 = {1'b0, acc_p1} + {2'b00, chunk};
      if (t_p1 >= P1) t_p1 = t_p1 - P1;
    end
    nxt_p1 = t_p1[N:0];
  end

endmodule

// File: rtl/rns_forward_seq.sv
// Sequential binary-to-RNS forward converter: folds the operand one N-bit
// chunk per cycle, with valid/ready handshakes on input and output.
module rns_forward_seq
  import rns_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res_m1,
  output logic [N-1:0] res_p0,
  output logic [N:0]   res_p1,
  output logic         busy
);

  localparam int unsigned K  = num_chunks(W, N);
  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [N-1:0] M1      = N'(mod_m1(N));
  localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

  state_t state, state_nxt;

  logic [W-1:0]   op;
  logic [K*N-1:0] op_pad;
  logic [IW-1:0]  idx;
  logic [N-1:0]   acc_m1, nxt_m1;
  logic [N:0]     acc_p1, nxt_p1;
  logic [N-1:0]   chunk;
  logic           accept, last;

  assign op_pad = (K*N)'(op);
  assign chunk  = op_pad[idx*N +: N];
  assign last   = (idx == IDX_LAST);

  rns_modstep #(.N(N)) u_step (
    .acc_m1 (acc_m1),
    .acc_p1 (acc_p1),
    .chunk  (chunk),
    .sub    (idx[0]),
    .nxt_m1 (nxt_m1),
    .nxt_p1 (nxt_p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op     <= '0;
      idx    <= '0;
      acc_m1 <= '0;
      acc_p1 <= '0;
      res_m1 <= '0;
      res_p0 <= '0;
      res_p1 <= '0;
    end else if (accept) begin
      op     <= in_data;
      idx    <= '0;
      acc_m1 <= '0;
      acc_p1 <= '0;
    end else if (state == ACCUM) begin
      acc_m1 <= nxt_m1;
      acc_p1 <= nxt_p1;
      if (idx == '0) res_p0 <= chunk;
      // Result registers load on the final chunk so they are valid with out_valid.
      if (last) begin
        res_m1 <= (nxt_m1 == M1) ? '0 : nxt_m1;
        res_p1 <= nxt_p1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rns_forward_seq.sv
// Directed and random bench for rns_forward_seq (N=4, W=13) with a
// scoreboard of expected residues computed from the operand.
module tb_rns_forward_seq;

  localparam int unsigned N = 4;
  localparam int unsigned W = 13;

  typedef struct {
    logic [31:0] m1;
    logic [31:0] p0;
    logic [31:0] p1;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] res_m1;
  logic [N-1:0] res_p0;
  logic [N:0]   res_p1;
  logic         busy;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  rns_forward_seq #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_m1    (res_m1),
    .res_p0    (res_p0),
    .res_p1    (res_p1),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit push);
    int unsigned n = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (push) begin
      e.m1 = 32'(d) % 15;
      e.p0 = 32'(d) % 16;
      e.p1 = 32'(d) % 17;
      sb.push_back(e);
    end
  endtask

  task automatic wait_out(input bit toggle);
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      if (out_valid || n >= 100) break;
      if (toggle) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b0;
    check("out_valid_arrives", 32'(out_valid), 32'd1);
  endtask

  task automatic recv(input int unsigned stall, input bit toggle);
    exp_t e;
    wait_out(toggle);
    if (!out_valid) return;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("res_m1", 32'(res_m1), e.m1);
      check("res_p0", 32'(res_p0), e.p0);
      check("res_p1", 32'(res_p1), e.p1);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0] h_m1, h_p0;
    logic [N:0]   h_p1;
    logic [W-1:0] r;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_res_m1",    32'(res_m1),    32'd0);
    check("rst_res_p0",    32'(res_p0),    32'd0);
    check("rst_res_p1",    32'(res_p1),    32'd0);
    rst = 1'b0;

    // Directed operands, including latency check on the first.
    send(13'h1ABC, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("latency_not_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check("latency_k_cycles", 32'(out_valid), 32'd1);
    recv(0, 1'b0);
    check("sb_lit_1abc", 32'(13'h1ABC) % 17, 32'd10);
    send(13'h1FFF, 1'b1); recv(0, 1'b0);
    send(13'd15,   1'b1); recv(0, 1'b0);
    send(13'd16,   1'b1); recv(1, 1'b0);

    // Backpressure hold with an ignored in_valid pulse.
    send(13'h1ABC, 1'b1);
    wait_out(1'b0);
    h_m1 = res_m1; h_p0 = res_p0; h_p1 = res_p1;
    for (int unsigned i = 0; i < 5; i++) begin
      if (i == 2) begin in_valid = 1'b1; in_data = 13'h0123; end
      else        in_valid = 1'b0;
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready",  32'(in_ready),  32'd0);
      check("hold_res_m1",    32'(res_m1),    32'(h_m1));
      check("hold_res_p0",    32'(res_p0),    32'(h_p0));
      check("hold_res_p1",    32'(res_p1),    32'(h_p1));
    end
    in_valid = 1'b0;
    recv(0, 1'b0);
    @(negedge clk);
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("pulse_ignored",     32'(busy),      32'd0);

    // Reset in the middle of accumulation.
    send(13'h1ABC, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_res_m1",    32'(res_m1),    32'd0);
    check("midrst_res_p0",    32'(res_p0),    32'd0);
    check("midrst_res_p1",    32'(res_p1),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(13'h0021, 1'b1); recv(0, 1'b0);

    // Random operands with random stalls and ready toggling.
    for (int unsigned i = 0; i < 1000; i++) begin
      r = W'($urandom);
      send(r, 1'b1);
      recv($urandom_range(0, 3), 1'b1);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
